// File: rtl/player_sprite_compositor_if.sv
// Pixel-stream, palette and sprite-ROM signals between the render path and the
// sprite compositor; the compositor takes the slave side.
interface player_sprite_compositor_if #(
   parameter int X_W    = 10,
   parameter int Y_W    = 10,
   parameter int ADDR_W = 12
);
   logic              i_frame_start;
   logic              i_pix_valid;
   logic [X_W-1:0]    i_x;
   logic [Y_W-1:0]    i_y;
   logic [23:0]       i_bg_rgb;
   logic [X_W-1:0]    i_pos_x;
   logic [Y_W-1:0]    i_pos_y;
   logic              i_shield_on;
   logic [23:0]       i_color_map [0:15];
   logic [ADDR_W-1:0] o_rom_addr;
   logic [3:0]        i_rom_data;
   logic [23:0]       o_rgb;
   logic              o_valid;
   logic              o_hit;

   modport master (
      output i_frame_start, i_pix_valid, i_x, i_y, i_bg_rgb, i_pos_x, i_pos_y,
             i_shield_on, i_color_map, i_rom_data,
      input  o_rom_addr, o_rgb, o_valid, o_hit
   );

   modport slave (
      input  i_frame_start, i_pix_valid, i_x, i_y, i_bg_rgb, i_pos_x, i_pos_y,
             i_shield_on, i_color_map, i_rom_data,
      output o_rom_addr, o_rgb, o_valid, o_hit
   );
endinterface

// File: rtl/player_sprite_compositor.sv
// Overlays a palettised sprite from a synchronous ROM on the background, 3-cycle latency.
// Optional macro SHIELD_BLINK_EN: sprite blinks per BLINK_FRAMES frames while the shield is on.
module player_sprite_compositor #(
   parameter int SPR_W        = 64,
   parameter int SPR_H        = 64,
   parameter int X_W          = 10,
   parameter int Y_W          = 10,
   parameter int BLINK_FRAMES = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   player_sprite_compositor_if.slave bus
);
   localparam int ADDR_W = $clog2(SPR_W * SPR_H);
   localparam int XB     = $clog2(SPR_W);
   localparam int YB     = ADDR_W - XB;
   localparam logic signed [X_W:0] SPR_W_S = (X_W+1)'(SPR_W);
   localparam logic signed [Y_W:0] SPR_H_S = (Y_W+1)'(SPR_H);

   logic [X_W-1:0]      px;
   logic [Y_W-1:0]      py;
   logic signed [X_W:0] dx;
   logic signed [Y_W:0] dy;
   logic                in_box;
   logic                visible;

   logic [ADDR_W-1:0]   rom_addr_p1;
   logic                vld_p1, inbox_p1;
   logic [23:0]         bg_p1;
   logic                vld_p2, inbox_p2;
   logic [23:0]         bg_p2;
   logic [23:0]         rgb_p3;
   logic                vld_p3, hit_p3;
   logic [3:0]          idx;
   logic                opaque;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         px <= '0;
         py <= '0;
      end else if (bus.i_frame_start) begin
         px <= bus.i_pos_x;
         py <= bus.i_pos_y;
      end
   end

   // Offsets are one bit wider than the scan so a box past the screen edge clips instead of wrapping.
   always_comb begin
      dx     = $signed({1'b0, bus.i_x}) - $signed({1'b0, px});
      dy     = $signed({1'b0, bus.i_y}) - $signed({1'b0, py});
      in_box = !dx[X_W] && (dx < SPR_W_S) && !dy[Y_W] && (dy < SPR_H_S);
   end

   // Stage 1: box test and ROM address
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rom_addr_p1 <= '0;
         vld_p1      <= 1'b0;
         inbox_p1    <= 1'b0;
      end else begin
         rom_addr_p1 <= in_box ? {dy[YB-1:0], dx[XB-1:0]} : '0;
         vld_p1      <= bus.i_pix_valid;
         inbox_p1    <= in_box;
      end
   end

   always_ff @(posedge i_clk) begin
      bg_p1 <= bus.i_bg_rgb;
   end

   // Stage 2: ROM access in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p2   <= 1'b0;
         inbox_p2 <= 1'b0;
      end else begin
         vld_p2   <= vld_p1;
         inbox_p2 <= inbox_p1;
      end
   end

   always_ff @(posedge i_clk) begin
      bg_p2 <= bg_p1;
   end

`ifdef SHIELD_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [CNT_W-1:0] blink_cnt;
   logic             phase;

   // Shield off overrides any frame-start wrap in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (!bus.i_shield_on) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (bus.i_frame_start) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign visible = ~phase;
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_shield;
   assign unused_shield = bus.i_shield_on;
   assign visible       = 1'b1;
`endif

   assign idx    = bus.i_rom_data;
   assign opaque = inbox_p2 && (idx != 4'd0) && visible;

   // Stage 3: palette lookup and overlay; invalid slots drive black
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rgb_p3 <= '0;
         vld_p3 <= 1'b0;
         hit_p3 <= 1'b0;
      end else begin
         vld_p3 <= vld_p2;
         hit_p3 <= opaque && vld_p2;
         if (!vld_p2)
            rgb_p3 <= '0;
         else if (opaque)
            rgb_p3 <= bus.i_color_map[idx];
         else
            rgb_p3 <= bg_p2;
      end
   end

   assign bus.o_rom_addr = rom_addr_p1;
   assign bus.o_rgb      = rgb_p3;
   assign bus.o_valid    = vld_p3;
   assign bus.o_hit      = hit_p3;
endmodule

// File: tb/tb_player_sprite_compositor.sv
// Directed checks of the sprite compositor against hand-computed pixels, with a synchronous ROM model.
module tb_player_sprite_compositor;
   localparam int X_W    = 10;
   localparam int Y_W    = 10;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   logic [3:0] rom [0:4095];

   player_sprite_compositor_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus ();

   player_sprite_compositor #(
      .SPR_W(64), .SPR_H(64), .X_W(X_W), .Y_W(Y_W), .BLINK_FRAMES(8)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic ev, input logic [23:0] ergb, input logic eh);
      chk({tag, ".valid"}, 32'(bus.o_valid), 32'(ev));
      chk({tag, ".rgb"},   32'(bus.o_rgb),   32'(ergb));
      chk({tag, ".hit"},   32'(bus.o_hit),   32'(eh));
   endtask

   task automatic send(input int x, input int y, input logic [23:0] bg, input logic v, input logic fs);
      bus.i_x           = X_W'(x);
      bus.i_y           = Y_W'(y);
      bus.i_bg_rgb      = bg;
      bus.i_pix_valid   = v;
      bus.i_frame_start = fs;
      step(1);
      bus.i_pix_valid   = 1'b0;
      bus.i_frame_start = 1'b0;
   endtask

   task automatic frame();
      send(0, 0, 24'h0, 1'b0, 1'b1);
   endtask

   task automatic pixel(input string tag, input int x, input int y, input logic [23:0] bg,
                        input int eaddr, input logic [23:0] ergb, input logic eh);
      send(x, y, bg, 1'b1, 1'b0);
      chk({tag, ".addr"}, 32'(bus.o_rom_addr), 32'(eaddr));
      step(2);
      expect_out(tag, 1'b1, ergb, eh);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 4'd0;
      rom[0]  = 4'd5;
      rom[65] = 4'd3;
      rom[39] = 4'd5;
      for (int i = 40; i < 64; i++) rom[i] = 4'd5;
      for (int i = 0; i < 16; i++) bus.i_color_map[i] = 24'h010101 * i;
      bus.i_color_map[0] = 24'hffffff;
      bus.i_color_map[3] = 24'h00ff00;
      bus.i_color_map[5] = 24'hc58039;

      rst_n             = 1'b0;
      bus.i_frame_start = 1'b0;
      bus.i_pix_valid   = 1'b0;
      bus.i_x           = '0;
      bus.i_y           = '0;
      bus.i_bg_rgb      = 24'h777777;
      bus.i_pos_x       = '0;
      bus.i_pos_y       = '0;
      bus.i_shield_on   = 1'b0;
      step(3);
      expect_out("reset", 1'b0, 24'h0, 1'b0);
      chk("reset.addr", 32'(bus.o_rom_addr), 32'd0);

      rst_n = 1'b1;
      step(10);
      expect_out("idle", 1'b0, 24'h0, 1'b0);

      // basic overlay at (100,50)
      bus.i_pos_x = 10'd100;
      bus.i_pos_y = 10'd50;
      frame();
      step(2);
      send(100, 50, 24'h123456, 1'b1, 1'b0);
      chk("basic.addr", 32'(bus.o_rom_addr), 32'd0);
      step(1);
      chk("basic.early_valid", 32'(bus.o_valid), 32'd0);
      step(1);
      expect_out("basic", 1'b1, 24'hc58039, 1'b1);
      pixel("opq2",   101,  51, 24'habcdef,   65, 24'h00ff00, 1'b1);
      pixel("left",    99,  50, 24'h123456,    0, 24'h123456, 1'b0);
      pixel("corner", 163, 113, 24'h222222, 4095, 24'h222222, 1'b0);
      pixel("right",  164,  50, 24'h333333,    0, 24'h333333, 1'b0);
      pixel("below",  100, 114, 24'h444444,    0, 24'h444444, 1'b0);

      send(100, 50, 24'h555555, 1'b0, 1'b0);
      step(2);
      expect_out("blank", 1'b0, 24'h0, 1'b0);

      // sprite hanging off the right edge of a 640-wide scan
      bus.i_pos_x = 10'd600;
      bus.i_pos_y = 10'd0;
      frame();
      pixel("clip639", 639,  0, 24'h010203, 39, 24'hc58039, 1'b1);
      pixel("clipx0",    0,  0, 24'h040506,  0, 24'h040506, 1'b0);
      pixel("clipx10",  10,  0, 24'h070809,  0, 24'h070809, 1'b0);
      pixel("clipx23",  23,  0, 24'h0a0b0c,  0, 24'h0a0b0c, 1'b0);
      pixel("clipy64", 639, 64, 24'h0d0e0f,  0, 24'h0d0e0f, 1'b0);

      // position only moves on frame start, and not for the coincident pixel
      bus.i_pos_x = 10'd100;
      bus.i_pos_y = 10'd50;
      pixel("keep", 639, 0, 24'h111111, 39, 24'hc58039, 1'b1);
      send(100, 50, 24'h666666, 1'b1, 1'b1);
      step(2);
      expect_out("fs_same", 1'b1, 24'h666666, 1'b0);
      pixel("fs_next", 100, 50, 24'h666666, 0, 24'hc58039, 1'b1);

`ifdef SHIELD_BLINK_EN
      bus.i_shield_on = 1'b1;
      pixel("blink.f0", 100, 50, 24'h202020, 0, 24'hc58039, 1'b1);
      repeat (7) frame();
      pixel("blink.f7", 100, 50, 24'h202020, 0, 24'hc58039, 1'b1);
      frame();
      pixel("blink.f8", 100, 50, 24'h202020, 0, 24'h202020, 1'b0);
      repeat (7) frame();
      pixel("blink.f15", 100, 50, 24'h202020, 0, 24'h202020, 1'b0);
      frame();
      pixel("blink.f16", 100, 50, 24'h202020, 0, 24'hc58039, 1'b1);
      repeat (8) frame();
      pixel("blink.f24", 100, 50, 24'h202020, 0, 24'h202020, 1'b0);
      bus.i_shield_on = 1'b0;
      pixel("blink.drop", 100, 50, 24'h202020, 0, 24'hc58039, 1'b1);

      bus.i_shield_on = 1'b1;
      repeat (7) frame();
      bus.i_shield_on = 1'b0;
      frame();
      bus.i_shield_on = 1'b1;
      pixel("coinc.vis", 100, 50, 24'h303030, 0, 24'hc58039, 1'b1);
      repeat (7) frame();
      pixel("coinc.cnt7", 100, 50, 24'h303030, 0, 24'hc58039, 1'b1);
      frame();
      pixel("coinc.hide", 100, 50, 24'h303030, 0, 24'h303030, 1'b0);
      bus.i_shield_on = 1'b0;
`else
      bus.i_shield_on = 1'b1;
      repeat (8) frame();
      pixel("noblink", 100, 50, 24'h202020, 0, 24'hc58039, 1'b1);
      bus.i_shield_on = 1'b0;
`endif

      // asynchronous reset with a pixel in flight
      send(100, 50, 24'h404040, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst.addr", 32'(bus.o_rom_addr), 32'd0);
      chk("arst.valid", 32'(bus.o_valid), 32'd0);
      rst_n = 1'b1;
      step(3);
      chk("arst.flushed", 32'(bus.o_valid), 32'd0);
      pixel("arst.pos0", 0, 0, 24'h505050, 0, 24'hc58039, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
